// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: FSM states, CMD byte layout
// and response codes.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_WDATA = 3'd2,
      ST_RLOAD = 3'd3,
      ST_RSEND = 3'd4,
      ST_ACK   = 3'd5,
      ST_ERR   = 3'd6
   } state_t;

   localparam int CMD_RW_BIT  = 7;
   localparam int CMD_RSVD_HI = 6;
   localparam int CMD_RSVD_LO = 3;
   localparam int CMD_LEN_HI  = 2;
   localparam int CMD_LEN_LO  = 0;

   localparam logic [7:0] RSP_ACK         = 8'hA5;
   localparam logic [7:0] RSP_ERR_CMD     = 8'hE1;
   localparam logic [7:0] RSP_ERR_TIMEOUT = 8'hE2;

endpackage

// File: rtl/uart_cmd_regbank.sv
// Register storage for the command parser: one write port, one combinational
// read port and a flattened view of every register.
module uart_cmd_regbank
   import uart_cmd_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 16,
   parameter int AW       = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic [AW-1:0]                waddr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [AW-1:0]                raddr,
   output logic [DATA_W-1:0]            rdata,
   output logic [NUM_REGS*DATA_W-1:0]   regs_flat
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_flat[g*DATA_W +: DATA_W] = mem[g];
   end

endmodule

// File: rtl/uart_cmd_regfile_burst.sv
// Byte-stream command parser: burst register reads/writes with address
// auto-increment, inter-byte timeout and ACK/error response bytes.
module uart_cmd_regfile_burst
   import uart_cmd_pkg::*;
#(
   parameter int NUM_REGS     = 16,
   parameter int DATA_BYTES   = 2,
   parameter int MAX_BURST    = 4,
   parameter int TIMEOUT_CLKS = 50000,
   parameter int ACK_EN       = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                rx_valid,
   input  logic [7:0]                          rx_data,
   input  logic                                tx_ready,
   output logic                                tx_valid,
   output logic [7:0]                          tx_data,
   output logic                                busy,
   output logic                                err,
   output logic [NUM_REGS*8*DATA_BYTES-1:0]    regs_flat
);

   localparam int DATA_W = 8 * DATA_BYTES;
   localparam int AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int TW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CLKS - 1);

   state_t              state, state_nxt;
   logic [7:0]          cmd, cmd_nxt;
   logic [AW-1:0]       addr, addr_nxt;
   logic [2:0]          bcnt, bcnt_nxt;
   logic [3:0]          rcnt, rcnt_nxt;
   logic [TW-1:0]       tcnt, tcnt_nxt;
   logic [DATA_W-1:0]   asm_q, asm_nxt;
   logic [DATA_W-1:0]   shreg, shreg_nxt;
   logic                wr_pend, wr_pend_nxt;
   logic                tx_valid_nxt, err_nxt;
   logic [7:0]          tx_data_nxt;
   logic [DATA_W-1:0]   rd_data;
   logic [2:0]          len_m1;
   logic                last_reg, byte_last, tx_done, cmd_bad;

   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      return (a == AW'(NUM_REGS - 1)) ? '0 : a + 1'b1;
   endfunction

   assign len_m1    = cmd[CMD_LEN_HI:CMD_LEN_LO];
   assign last_reg  = (rcnt == {1'b0, len_m1});
   assign byte_last = (bcnt == 3'(DATA_BYTES - 1));
   assign tx_done   = tx_valid & tx_ready;
   assign cmd_bad   = (cmd[CMD_RSVD_HI:CMD_RSVD_LO] != 4'd0) ||
                      ({1'b0, len_m1} >= 4'(MAX_BURST)) ||
                      ({1'b0, rx_data} >= 9'(NUM_REGS));

   // The write is issued the cycle after the last data byte, from the
   // assembled word held in asm_q.
   uart_cmd_regbank #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .AW       (AW)
   ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .we        (wr_pend),
      .waddr     (addr),
      .wdata     (asm_q),
      .raddr     (addr),
      .rdata     (rd_data),
      .regs_flat (regs_flat)
   );

   always_comb begin
      state_nxt    = state;
      cmd_nxt      = cmd;
      addr_nxt     = addr;
      bcnt_nxt     = bcnt;
      rcnt_nxt     = rcnt;
      tcnt_nxt     = '0;
      asm_nxt      = asm_q;
      shreg_nxt    = shreg;
      wr_pend_nxt  = 1'b0;
      tx_valid_nxt = tx_valid;
      tx_data_nxt  = tx_data;
      err_nxt      = 1'b0;

      case (state)
         ST_IDLE: begin
            if (rx_valid) begin
               cmd_nxt   = rx_data;
               bcnt_nxt  = '0;
               rcnt_nxt  = '0;
               state_nxt = ST_ADDR;
            end
         end

         ST_ADDR: begin
            tcnt_nxt = tcnt + 1'b1;
            if (rx_valid) begin
               tcnt_nxt = '0;
               addr_nxt = rx_data[AW-1:0];
               if (cmd_bad) begin
                  state_nxt    = ST_ERR;
                  err_nxt      = 1'b1;
                  tx_valid_nxt = 1'b1;
                  tx_data_nxt  = RSP_ERR_CMD;
               end else if (cmd[CMD_RW_BIT]) begin
                  state_nxt = ST_WDATA;
               end else begin
                  state_nxt = ST_RLOAD;
               end
            end else if (tcnt == TLIM) begin
               tcnt_nxt     = '0;
               state_nxt    = ST_ERR;
               err_nxt      = 1'b1;
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = RSP_ERR_TIMEOUT;
            end
         end

         ST_WDATA: begin
            tcnt_nxt = rx_valid ? '0 : tcnt + 1'b1;
            // A byte arriving while the final write retires has no frame
            // to belong to and is rejected.
            if (rx_valid && !(wr_pend && last_reg)) begin
               asm_nxt = (asm_q << 8) | DATA_W'(rx_data);
               if (byte_last) begin
                  bcnt_nxt    = '0;
                  wr_pend_nxt = 1'b1;
               end else begin
                  bcnt_nxt = bcnt + 1'b1;
               end
            end else if (rx_valid) begin
               err_nxt = 1'b1;
            end
            if (wr_pend) begin
               addr_nxt = addr_inc(addr);
               rcnt_nxt = rcnt + 1'b1;
               if (last_reg) begin
                  tcnt_nxt = '0;
                  if (ACK_EN != 0) begin
                     state_nxt    = ST_ACK;
                     tx_valid_nxt = 1'b1;
                     tx_data_nxt  = RSP_ACK;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end
            end else if (!rx_valid && tcnt == TLIM) begin
               tcnt_nxt     = '0;
               state_nxt    = ST_ERR;
               err_nxt      = 1'b1;
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = RSP_ERR_TIMEOUT;
            end
         end

         ST_RLOAD: begin
            err_nxt      = rx_valid;
            shreg_nxt    = rd_data << 8;
            tx_data_nxt  = rd_data[DATA_W-1 -: 8];
            tx_valid_nxt = 1'b1;
            bcnt_nxt     = '0;
            state_nxt    = ST_RSEND;
         end

         ST_RSEND: begin
            err_nxt = rx_valid;
            if (tx_done) begin
               if (byte_last) begin
                  tx_valid_nxt = 1'b0;
                  addr_nxt     = addr_inc(addr);
                  rcnt_nxt     = rcnt + 1'b1;
                  state_nxt    = last_reg ? ST_IDLE : ST_RLOAD;
               end else begin
                  tx_data_nxt = shreg[DATA_W-1 -: 8];
                  shreg_nxt   = shreg << 8;
                  bcnt_nxt    = bcnt + 1'b1;
               end
            end
         end

         ST_ACK, ST_ERR: begin
            err_nxt = rx_valid;
            if (tx_done) begin
               tx_valid_nxt = 1'b0;
               state_nxt    = ST_IDLE;
            end
         end

         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cmd      <= '0;
         addr     <= '0;
         bcnt     <= '0;
         rcnt     <= '0;
         tcnt     <= '0;
         asm_q    <= '0;
         shreg    <= '0;
         wr_pend  <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cmd      <= cmd_nxt;
         addr     <= addr_nxt;
         bcnt     <= bcnt_nxt;
         rcnt     <= rcnt_nxt;
         tcnt     <= tcnt_nxt;
         asm_q    <= asm_nxt;
         shreg    <= shreg_nxt;
         wr_pend  <= wr_pend_nxt;
         tx_valid <= tx_valid_nxt;
         tx_data  <= tx_data_nxt;
         err      <= err_nxt;
         busy     <= (state_nxt != ST_IDLE);
      end
   end

endmodule

// File: doc/uart_cmd_regfile_burst.md
Name: uart_cmd_regfile_burst

Overview:
Parametrised successor to the single-byte UART command parser and register file. It consumes a byte stream from the UART receiver and drives a byte stream to the UART transmitter. It adds multi-byte registers, burst read/write with address auto-increment, an inter-byte timeout, and ACK/error response bytes. It sits between uart_rx and uart_tx inside the top level.

Parameters:
NUM_REGS, 16, number of registers (2..256)
DATA_BYTES, 2, bytes per register (1..4); DATA_W = 8*DATA_BYTES
MAX_BURST, 4, maximum registers per command (1..8)
TIMEOUT_CLKS, 50000, clocks allowed between received bytes inside a frame
ACK_EN, 1, send ACK byte after a completed write

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_ready  in  1  transmitter idle, able to accept a byte
tx_valid  out  1  byte on tx_data offered to the transmitter
tx_data  out  8  byte to transmit
busy  out  1  high whenever the FSM is not in IDLE
err  out  1  one-cycle pulse on any protocol error
regs_flat  out  NUM_REGS*DATA_W  all registers; reg i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset: synchronous, active-high. All registers 0; tx_valid=0, tx_data=0, busy=0, err=0; FSM to IDLE; counters 0. Asserting reset mid-frame aborts the frame and emits nothing.
- Frame format: CMD, ADDR, then data bytes for writes only.
  - CMD[7]=1 means write, CMD[7]=0 means read.
  - CMD[2:0] = LEN-1, so LEN is 1..8.
  - CMD[6:3] must be 0.
- Register data is sent MSB byte first.
- TX handshake: tx_valid and tx_data are held stable until a cycle where tx_valid and tx_ready are both 1. That cycle is the transfer; tx_valid is dropped, or the next byte is presented, on the following cycle.
- States:
  - IDLE: on rx_valid, latch CMD and go to ADDR.
  - ADDR: on rx_valid, latch the address.
    - If CMD[6:3]!=0, LEN>MAX_BURST, or ADDR>=NUM_REGS: go to ERR with code 0xE1.
    - Otherwise go to WDATA for a write, or RLOAD for a read.
  - WDATA: shift bytes into the assembly register.
    - After DATA_BYTES bytes, write reg[addr] in the cycle after the final rx_valid.
    - Then increment addr, wrapping NUM_REGS-1 to 0, and increment the register count.
    - After LEN registers: go to ACK if ACK_EN, else IDLE.
  - RLOAD: snapshot reg[addr] into the shift register; go to RSEND.
  - RSEND: send DATA_BYTES bytes MSB first.
    - Then increment addr (same wrap rule).
    - Go to RLOAD if registers remain, else IDLE.
  - ACK: send 0xA5, then IDLE.
  - ERR: pulse err for one cycle on entry, send the error code, then IDLE.
- Timeout: a counter resets on every rx_valid. It runs in ADDR and WDATA only.
  - Reaching TIMEOUT_CLKS goes to ERR with code 0xE2.
  - Registers already fully written stay written; a partially assembled register is discarded.
- rx_valid in RLOAD, RSEND, ACK or ERR: byte dropped, err pulsed, state unaffected.
- Read latency: the first tx_valid is asserted 2 cycles after the rx_valid of the ADDR byte.
- Same-cycle events: a register write and a read snapshot of the same register cannot coincide, because the FSM serialises them.
- busy is a registered output, high in every state except IDLE.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - FSM state encoding;
  - CMD field positions: RW bit 7, RSVD [6:3], LEN [2:0];
  - response codes: ACK 0xA5, ERR_CMD 0xE1, ERR_TIMEOUT 0xE2.
- One natural sub-module, uart_cmd_regbank: NUM_REGS x DATA_W storage with a write port (we, waddr, wdata), a combinational read port, and the flattened output regs_flat.
- The parser FSM, counters and TX holding register stay in the top block.

Test Plan:
- Single write: bytes 0x80, 0x05, 0xAA, 0x55. Expect reg[5]=0xAA55, then a TX byte 0xA5, err never pulses, busy returns to 0.
- Burst write then read: write 0x82 to address 0x0E with words 0x1111, 0x2222, 0x3333 (LEN=3, wraps). Expect reg[14]=0x1111, reg[15]=0x2222, reg[0]=0x3333. Then read 0x02 at 0x0E; expect TX 11 11 22 22 33 33 in order.
- Invalid commands:
  - 0x80 then address 0x10 (out of range): TX 0xE1, one err pulse, no register changes.
  - CMD 0xC0 (reserved bit set): TX 0xE1.
- Timeout: send 0x80, 0x03, 0x12, then silence for TIMEOUT_CLKS+10 clocks. Expect TX 0xE2, reg[3] unchanged, FSM in IDLE. A following valid frame is accepted normally.
- TX backpressure: issue read 0x01 at 0x00 with tx_ready held low for 100 clocks. tx_valid and tx_data must stay stable; exactly 4 bytes are sent once tx_ready rises. A byte injected during RSEND pulses err and does not corrupt the output.
- Reset mid-frame: assert reset after CMD 0x80 and ADDR 0x02. Expect all outputs 0 the next cycle, regs_flat=0, and no TX byte.
